// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory request router and its address decoder.
package dmem_pkg;

  typedef enum logic {TGT_RAM = 1'b0, TGT_MMIO = 1'b1} dmem_tgt_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} dmem_state_e;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_MMIO_MASK = 32'hF000_0000;
  localparam logic [31:0] TIMEOUT_RDATA     = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_CNT_W     = 16;

endpackage

// File: rtl/dmem_router_if.sv
// Core-side request/response channel plus both target ports of the data-memory router.
interface dmem_router_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] out_addr;
  logic        out_we;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;

  logic        ram_req_valid;
  logic        ram_req_ready;
  logic        ram_rsp_valid;
  logic [31:0] ram_rsp_rdata;

  logic        mmio_req_valid;
  logic        mmio_req_ready;
  logic        mmio_rsp_valid;
  logic [31:0] mmio_rsp_rdata;

  // Router side
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output out_addr, out_we, out_wdata, out_be,
    output ram_req_valid, mmio_req_valid,
    input  ram_req_ready, ram_rsp_valid, ram_rsp_rdata,
    input  mmio_req_ready, mmio_rsp_valid, mmio_rsp_rdata
  );

  // Core and targets side
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  out_addr, out_we, out_wdata, out_be,
    input  ram_req_valid, mmio_req_valid,
    output ram_req_ready, ram_rsp_valid, ram_rsp_rdata,
    output mmio_req_ready, mmio_rsp_valid, mmio_rsp_rdata
  );

endinterface

// File: rtl/dmem_addr_decode.sv
// Combinational address-to-target decode, shared with any other bus master.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK = DEFAULT_MMIO_MASK
) (
  input  logic [31:0] addr,
  output dmem_tgt_e   tgt
);

  assign tgt = ((addr & MMIO_MASK) == MMIO_BASE) ? TGT_MMIO : TGT_RAM;

endmodule

// File: rtl/dmem_router.sv
// Steers one outstanding data-memory request to RAM or MMIO and relays the response.
// Optional BUSY watchdog enabled by defining DMEM_ROUTER_TIMEOUT_EN.
module dmem_router
  import dmem_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE      = DEFAULT_MMIO_BASE,
  parameter logic [31:0] MMIO_MASK      = DEFAULT_MMIO_MASK,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst_n,
  dmem_router_if.slave bus
);

  dmem_state_e state_reg, state_next;
  dmem_tgt_e   tgt_reg, tgt_next;
  dmem_tgt_e   dec_tgt;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        req_ready_c, ram_req_valid_c, mmio_req_valid_c;
  logic        sel_ready, honoured;

  dmem_addr_decode #(
    .MMIO_BASE(MMIO_BASE),
    .MMIO_MASK(MMIO_MASK)
  ) u_decode (
    .addr(bus.req_addr),
    .tgt (dec_tgt)
  );

  assign sel_ready = (dec_tgt == TGT_MMIO) ? bus.mmio_req_ready : bus.ram_req_ready;
  assign honoured  = (tgt_reg == TGT_MMIO) ? bus.mmio_rsp_valid : bus.ram_rsp_valid;

`ifdef DMEM_ROUTER_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_CNT_W-1:0] cnt_reg, cnt_next;
  logic                     rsp_err_reg, rsp_err_next;
`endif

  always_comb begin
    state_next       = state_reg;
    tgt_next         = tgt_reg;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
    req_ready_c      = 1'b0;
    ram_req_valid_c  = 1'b0;
    mmio_req_valid_c = 1'b0;
`ifdef DMEM_ROUTER_TIMEOUT_EN
    cnt_next         = cnt_reg;
    rsp_err_next     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        req_ready_c      = sel_ready;
        ram_req_valid_c  = bus.req_valid && (dec_tgt == TGT_RAM);
        mmio_req_valid_c = bus.req_valid && (dec_tgt == TGT_MMIO);
        if (bus.req_valid && sel_ready) begin
          tgt_next   = dec_tgt;
          state_next = ST_BUSY;
`ifdef DMEM_ROUTER_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef DMEM_ROUTER_TIMEOUT_EN
        cnt_next = cnt_reg + 1'b1;
`endif
        // A real response beats a coincident timeout.
        if (honoured) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = (tgt_reg == TGT_MMIO) ? bus.mmio_rsp_rdata : bus.ram_rsp_rdata;
          state_next     = ST_IDLE;
        end
`ifdef DMEM_ROUTER_TIMEOUT_EN
        else if (cnt_reg == TO_LAST) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = TIMEOUT_RDATA;
          rsp_err_next   = 1'b1;
          state_next     = ST_IDLE;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      tgt_reg       <= TGT_RAM;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
`ifdef DMEM_ROUTER_TIMEOUT_EN
      cnt_reg       <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      tgt_reg       <= tgt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
`ifdef DMEM_ROUTER_TIMEOUT_EN
      cnt_reg       <= cnt_next;
      rsp_err_reg   <= rsp_err_next;
`endif
    end
  end

  // Combinational handshake outputs are held low while reset is asserted.
  assign bus.req_ready      = rst_n & req_ready_c;
  assign bus.ram_req_valid  = rst_n & ram_req_valid_c;
  assign bus.mmio_req_valid = rst_n & mmio_req_valid_c;

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
`ifdef DMEM_ROUTER_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_reg;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign bus.out_addr  = bus.req_addr;
  assign bus.out_we    = bus.req_we;
  assign bus.out_wdata = bus.req_wdata;
  assign bus.out_be    = bus.req_be;

endmodule

// File: doc/dmem_router.md
# dmem_router

Routes the core's single data-memory request channel to one of two targets, the data RAM or the MMIO peripheral block, and steers the selected target's response back to the core. It is the request-side counterpart of the core's read-data select path. It sits between the load/store datapath and the memory/peripheral ports. At most one transaction is outstanding.

## Interface
Parameters:
- MMIO_BASE, 32'h1000_0000, MMIO region base address.
- MMIO_MASK, 32'hF000_0000, bits compared against MMIO_BASE.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before an error response. Used only with the timeout feature compiled in.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  router accepts the request this cycle.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables.
- rsp_valid  out  1  one-cycle response strobe to the core.
- rsp_rdata  out  32  load data.
- rsp_err  out  1  response is an error.
- out_addr, out_we, out_wdata, out_be  out  32/1/32/4  request fields forwarded to both targets, equal to the core inputs.
- ram_req_valid / mmio_req_valid  out  1  request valid to each target.
- ram_req_ready / mmio_req_ready  in  1  target ready.
- ram_rsp_valid / mmio_rsp_valid  in  1  target response strobe.
- ram_rsp_rdata / mmio_rsp_rdata  in  32  target read data.

## Operation
Decode (combinational):
- Target is MMIO when (req_addr & MMIO_MASK) == MMIO_BASE; otherwise RAM.

States:
- IDLE
  - Selected target's req_valid = req_valid; the other target's req_valid = 0.
  - req_ready = selected target's ready.
  - On the handshake (req_valid && req_ready): latch the target into tgt_q and go to BUSY.
- BUSY
  - req_ready = 0 and both target req_valid = 0.
  - Only the tgt_q target's rsp_valid is honoured. A response strobe from the other target is ignored.
  - On the honoured strobe: register rsp_rdata = target rdata, rsp_valid = 1, rsp_err = 0, then go to IDLE.

Other rules:
- Stores still wait for the target's rsp_valid (write acknowledge). rsp_rdata for a store is whatever the target drives.
- A response strobe arriving in IDLE is dropped.
- Reset asserted mid-transaction abandons the transaction: FSM goes to IDLE and no response is issued.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, ram_req_valid = 0, mmio_req_valid = 0, state = IDLE, tgt_q = RAM, timeout counter = 0.
- Request path is combinational: the handshake completes in the cycle where both valid and ready are high.
- Response latency: rsp_valid rises exactly 1 cycle after the target's rsp_valid, lasts 1 cycle, and coincides with the return to IDLE.
- Back-to-back: a new request can be accepted in the cycle rsp_valid is high.
- Minimum turnaround (accept to response): 2 cycles.

## Configuration
- DMEM_ROUTER_TIMEOUT_EN defined:
  - An 8–16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no honoured response: rsp_valid = 1, rsp_err = 1, rsp_rdata = 32'hDEAD_BEEF, go to IDLE.
  - A target response in the same cycle as the timeout wins (normal response, rsp_err = 0).
  - Targets must not respond after a timeout.
- DMEM_ROUTER_TIMEOUT_EN undefined:
  - No counter; rsp_err is tied to 0.
  - BUSY waits indefinitely.

## Structure
- dmem_pkg holds:
  - typedef enum logic {TGT_RAM, TGT_MMIO} dmem_tgt_e
  - typedef enum logic {ST_IDLE, ST_BUSY} dmem_state_e
  - default MMIO_BASE / MMIO_MASK constants
  - localparam TIMEOUT_RDATA = 32'hDEAD_BEEF
- Sub-module dmem_addr_decode: combinational address to dmem_tgt_e, reusable by other bus masters.

## Test plan
- Load from 32'h0000_0040, RAM ready, ram_rsp_valid 1 cycle later with rdata 32'h1234_5678 -> mmio_req_valid stays 0; rsp_valid 1 cycle later with rdata 32'h1234_5678, rsp_err 0.
- Store to 32'h1000_0004 with mmio_req_ready held low 3 cycles -> req_ready low for those 3 cycles; accepted on the 4th; response relayed with latency 1.
- In BUSY on RAM, assert a spurious mmio_rsp_valid -> ignored; only ram_rsp_valid produces rsp_valid.
- Assert rst_n low while BUSY -> all outputs at reset values immediately; a later ram_rsp_valid produces no response.
- With DMEM_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, the target never responds -> rsp_valid with rsp_err 1 and rdata 32'hDEAD_BEEF; the next request is accepted normally.
- Back-to-back loads RAM then MMIO -> second accepted in the cycle of the first rsp_valid; responses in order with correct data.
